// File: rtl/ascon_pkg.sv
// Shared definitions for the masked Ascon-p round scheduler.
package ascon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RND,
    ST_CHI,
    ST_UPD,
    ST_DONE
  } sched_state_t;

  localparam int ROUNDS_MAX = 12;

  // Out-of-range round requests fall back to the full permutation.
  function automatic logic [3:0] clamp_rounds(input logic [3:0] r);
    return (r == 4'd0 || r > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : r;
  endfunction

endpackage

// File: rtl/asconp_sched.sv
// Round scheduler for a masked Ascon-p core: randomness handshake, DOM-AND capture, state update.
// Optional ASCONP_SCHED_ZEROIZE_EN: state_o exposed only with done_o, rdi cleared on each update.
//
// state    | meaning
// IDLE     | waiting for start_i
// WAIT_RND | requesting fresh randomness for the next round
// CHI      | state/rdi held while the DOM-AND stage captures
// UPD      | state register takes the round output, cnt decrements
// DONE     | one-cycle result pulse
module asconp_sched
  import ascon_pkg::*;
#(
  parameter int D        = 2,
  parameter int RDI_BITS = D*(D-1)/2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [3:0]               rounds_i,
  input  logic [5*D*64-1:0]        state_i,
  input  logic                     rnd_valid_i,
  input  logic [5*64*RDI_BITS-1:0] rnd_i,
  output logic                     rnd_ready_o,
  output logic [3:0]               perm_round_cnt_o,
  output logic [5*64*RDI_BITS-1:0] perm_rdi_o,
  output logic [5*D*64-1:0]        perm_x_o,
  input  logic [5*D*64-1:0]        perm_x_i,
  output logic [5*D*64-1:0]        state_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int SW = 5*D*64;
  localparam int RW = 5*64*RDI_BITS;

  sched_state_t  st_q;
  logic [3:0]    cnt_q;
  logic [SW-1:0] x_q;
  logic [RW-1:0] rdi_q;
  logic          busy_q;
  logic          done_q;
  logic          rnd_ready_q;
  logic          rnd_hs;

  assign rnd_hs = rnd_valid_i & rnd_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= 4'd0;
      x_q         <= '0;
      rdi_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rnd_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start_i) begin
            x_q         <= state_i;
            cnt_q       <= clamp_rounds(rounds_i);
            st_q        <= ST_WAIT_RND;
            busy_q      <= 1'b1;
            rnd_ready_q <= 1'b1;
          end
        end
        ST_WAIT_RND: begin
          if (rnd_hs) begin
            rdi_q       <= rnd_i;
            st_q        <= ST_CHI;
            rnd_ready_q <= 1'b0;
          end
        end
        ST_CHI: begin
          st_q        <= ST_UPD;
          rnd_ready_q <= (cnt_q > 4'd1);
        end
        ST_UPD: begin
          x_q   <= perm_x_i;
          cnt_q <= cnt_q - 4'd1;
`ifdef ASCONP_SCHED_ZEROIZE_EN
          rdi_q <= '0;
`endif
          if (cnt_q == 4'd1) begin
            st_q        <= ST_DONE;
            done_q      <= 1'b1;
            rnd_ready_q <= 1'b0;
          end else if (rnd_hs) begin
            // a fresh word latched here overrides the clear, the next round needs it
            rdi_q       <= rnd_i;
            st_q        <= ST_CHI;
            rnd_ready_q <= 1'b0;
          end else begin
            st_q        <= ST_WAIT_RND;
            rnd_ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          st_q        <= ST_IDLE;
          busy_q      <= 1'b0;
          rnd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rnd_ready_o      = rnd_ready_q;
  assign perm_round_cnt_o = cnt_q;
  assign perm_rdi_o       = rdi_q;
  assign perm_x_o         = x_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

`ifdef ASCONP_SCHED_ZEROIZE_EN
  assign state_o = done_q ? x_q : '0;
`else
  assign state_o = x_q;
`endif

endmodule

// File: tb/tb_asconp_sched.sv
// Self-checking bench for asconp_sched with a behavioural Ascon-p stand-in and timing model.
`timescale 1ns/1ps
module tb_asconp_sched;

  localparam int D  = 2;
  localparam int SW = 5*D*64;
  localparam int RW = 5*64*(D*(D-1)/2);
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [3:0]    rounds_i = 4'd0;
  logic [SW-1:0] state_i = '0;
  logic          rnd_valid_i = 1'b0;
  logic [RW-1:0] rnd_i = '0;
  logic          rnd_ready_o;
  logic [3:0]    perm_round_cnt_o;
  logic [RW-1:0] perm_rdi_o;
  logic [SW-1:0] perm_x_o;
  logic [SW-1:0] perm_x_i;
  logic [SW-1:0] state_o;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_fail   = 0;

  asconp_sched #(.D(D)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rounds_i(rounds_i), .state_i(state_i),
    .rnd_valid_i(rnd_valid_i), .rnd_i(rnd_i), .rnd_ready_o(rnd_ready_o),
    .perm_round_cnt_o(perm_round_cnt_o), .perm_rdi_o(perm_rdi_o), .perm_x_o(perm_x_o),
    .perm_x_i(perm_x_i), .state_o(state_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference Ascon-p (unshared, 5 x 64-bit words) ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input int t);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0] c;
    x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192]; x4 = s[319:256];
    c  = 8'(((15 - t) << 4) | t);
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] u, input int nr);
    logic [319:0] s = u;
    for (int t = 12 - nr; t < 12; t++) s = ascon_round(s, t);
    return s;
  endfunction

  function automatic logic [319:0] unshare(input logic [SW-1:0] sh);
    logic [319:0] u = '0;
    for (int w = 0; w < 5; w++)
      for (int s = 0; s < D; s++) u[w*64 +: 64] = u[w*64 +: 64] ^ sh[(w*D + s)*64 +: 64];
    return u;
  endfunction

  function automatic logic [SW-1:0] share0(input logic [319:0] u);
    logic [SW-1:0] sh = '0;
    for (int w = 0; w < 5; w++) sh[(w*D)*64 +: 64] = u[w*64 +: 64];
    return sh;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] v;
    for (int i = 0; i < SW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RW-1:0] rand_rnd();
    logic [RW-1:0] v;
    for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int clamp(input int r);
    return (r == 0 || r > 12) ? 12 : r;
  endfunction

  // Stand-in for the asconp instance: one round on the recombined state, index from cnt.
  always_comb perm_x_i = share0(ascon_round(unshare(perm_x_o), 12 - int'(perm_round_cnt_o)));

  // ---------------- valid pattern and timing model ----------------
  bit vpat [MAXC];

  task automatic fill_valid(input int pct);
    for (int i = 0; i < MAXC; i++) vpat[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Each round needs one handshake, then CHI and UPD; UPD may already take the next word.
  function automatic int exp_done(input int nr);
    int avail = 1;
    int h;
    for (int r = 0; r < nr; r++) begin
      h = avail;
      while (h < MAXC - 1 && !vpat[h]) h++;
      avail = h + 2;
    end
    return avail + 1;
  endfunction

  // ---------------- run driver ----------------
  int            r_done, r_hs, r_rdi_err, r_leak;
  logic [SW-1:0] r_res, r_post_state;
  logic [RW-1:0] r_last_w, r_post_rdi;
  logic          r_post_done, r_post_busy, r_abort_zero;
  int            chi_cnts[$];

  task automatic run_perm(input logic [3:0] rounds, input logic [SW-1:0] st,
                          input int poke_a, input int poke_b, input int abort_cyc);
    logic chi_pending = 1'b0;
    logic aborted = 1'b0;
    r_done = -1; r_hs = 0; r_rdi_err = 0; r_leak = 0; r_abort_zero = 1'b0;
    r_last_w = '0;
    chi_cnts.delete();
    @(posedge clk); #1;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      start_i = (cyc == 0) || (cyc == poke_a) || (cyc == poke_b);
      if (cyc == 0) begin
        rounds_i = rounds; state_i = st;
      end else if (start_i) begin
        rounds_i = 4'd3; state_i = rand_state();
      end
      rnd_valid_i = vpat[cyc];
      rnd_i = rand_rnd();
      if (cyc == abort_cyc) begin
        #2 rst = 1'b1;
        #1;
        r_abort_zero = !busy_o && !done_o && !rnd_ready_o && perm_round_cnt_o == 4'd0 &&
                       perm_x_o == '0 && perm_rdi_o == '0 && state_o == '0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      if (chi_pending) begin
        if (perm_rdi_o !== r_last_w) r_rdi_err++;
        chi_cnts.push_back(int'(perm_round_cnt_o));
        chi_pending = 1'b0;
      end
      if (rnd_ready_o && rnd_valid_i) begin
        r_hs++;
        r_last_w = rnd_i;
        chi_pending = 1'b1;
      end
`ifdef ASCONP_SCHED_ZEROIZE_EN
      if (!done_o && state_o !== '0) r_leak++;
`endif
      if (done_o) begin
        r_done = cyc;
        r_res = state_o;
        break;
      end
      @(posedge clk); #1;
    end
    if (!aborted) begin
      @(posedge clk); #1;
      start_i = 1'b0; rnd_valid_i = 1'b0;
      @(negedge clk);
      r_post_done = done_o; r_post_busy = busy_o;
      r_post_state = state_o; r_post_rdi = perm_rdi_o;
    end
    start_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [SW-1:0] st;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rnd_ready_o !== 1'b0 || perm_round_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b ready=%b cnt=%0d, required all 0",
               busy_o, done_o, rnd_ready_o, perm_round_cnt_o);
    end
    n_checks++;
    if (perm_x_o !== '0 || perm_rdi_o !== '0 || state_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: state/rdi registers not zero during reset");
    end
    st = rand_state();
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b1; rounds_i = 4'd12; state_i = st; rnd_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || rnd_ready_o !== 1'b1 || perm_round_cnt_o !== 4'd12) begin
      n_fail++;
      $display("FAIL first_start: busy=%b ready=%b cnt=%0d, required 1 1 12",
               busy_o, rnd_ready_o, perm_round_cnt_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_cnt_seq(input string name, input int nr);
    logic ok = (chi_cnts.size() == nr);
    for (int i = 0; i < chi_cnts.size() && ok; i++) if (chi_cnts[i] != nr - i) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %0d CHI rounds seen, first cnt %0d, required %0d rounds counting %0d..1",
               name, chi_cnts.size(), (chi_cnts.size() > 0) ? chi_cnts[0] : -1, nr, nr);
    end
  endtask

  task automatic test_p12_zero();
    logic [319:0] gold;
    fill_valid(100);
    gold = ref_perm('0, 12);
    run_perm(4'd12, '0, -1, -1, -1);
    n_checks++;
    if (r_done !== 26) begin
      n_fail++; $display("FAIL p12_latency: done at cycle %0d, required 26", r_done);
    end
    n_checks++;
    if (unshare(r_res) !== gold) begin
      n_fail++; $display("FAIL p12_result: got %h required %h", unshare(r_res), gold);
    end
    n_checks++;
    if (r_hs !== 12 || r_rdi_err !== 0) begin
      n_fail++; $display("FAIL p12_rnd: handshakes %0d rdi errors %0d, required 12 and 0", r_hs, r_rdi_err);
    end
    check_cnt_seq("p12_cnt", 12);
    n_checks++;
    if (r_post_done !== 1'b0 || r_post_busy !== 1'b0) begin
      n_fail++; $display("FAIL p12_pulse: done=%b busy=%b after done, required 0 0", r_post_done, r_post_busy);
    end
`ifdef ASCONP_SCHED_ZEROIZE_EN
    n_checks++;
    if (r_leak !== 0 || r_post_state !== '0 || r_post_rdi !== '0) begin
      n_fail++; $display("FAIL zeroize: leak cycles %0d, idle state/rdi nonzero=%b", r_leak,
                         (r_post_state != '0) || (r_post_rdi != '0));
    end
`else
    n_checks++;
    if (r_post_state !== r_res || r_post_rdi !== r_last_w) begin
      n_fail++; $display("FAIL hold: state held=%b rdi held=%b, required 1 1",
                         r_post_state === r_res, r_post_rdi === r_last_w);
    end
`endif
  endtask

  task automatic test_p6_masked();
    logic [SW-1:0] st = rand_state();
    fill_valid(100);
    run_perm(4'd6, st, -1, -1, -1);
    n_checks++;
    if (r_done !== 14) begin
      n_fail++; $display("FAIL p6_latency: done at cycle %0d, required 14", r_done);
    end
    n_checks++;
    if (unshare(r_res) !== ref_perm(unshare(st), 6)) begin
      n_fail++; $display("FAIL p6_result: got %h required %h", unshare(r_res), ref_perm(unshare(st), 6));
    end
    check_cnt_seq("p6_cnt", 6);
  endtask

  task automatic test_stall();
    logic [SW-1:0] st = rand_state();
    fill_valid(100);
    vpat[7] = 1'b0; vpat[8] = 1'b0; vpat[9] = 1'b0;
    run_perm(4'd12, st, -1, -1, -1);
    n_checks++;
    if (r_done !== 29 || exp_done(12) !== 29) begin
      n_fail++; $display("FAIL stall_latency: done at cycle %0d, required 29", r_done);
    end
    n_checks++;
    if (unshare(r_res) !== ref_perm(unshare(st), 12) || r_hs !== 12 || r_rdi_err !== 0) begin
      n_fail++; $display("FAIL stall_result: result ok=%b handshakes %0d rdi errors %0d",
                         unshare(r_res) === ref_perm(unshare(st), 12), r_hs, r_rdi_err);
    end
  endtask

  task automatic test_clamp_and_ignore();
    logic [3:0] rr [2];
    logic [SW-1:0] st;
    rr[0] = 4'd0; rr[1] = 4'd15;
    for (int k = 0; k < 2; k++) begin
      st = rand_state();
      fill_valid(100);
      run_perm(rr[k], st, 5, 26, -1);
      n_checks++;
      if (r_done !== 26 || unshare(r_res) !== ref_perm(unshare(st), 12)) begin
        n_fail++; $display("FAIL clamp_r%0d: done at %0d result ok=%b, required 26 and p12",
                           rr[k], r_done, unshare(r_res) === ref_perm(unshare(st), 12));
      end
      n_checks++;
      if (r_post_busy !== 1'b0) begin
        n_fail++; $display("FAIL start_in_done_r%0d: busy=%b after done, required 0", rr[k], r_post_busy);
      end
    end
  endtask

  task automatic test_random_valid();
    logic [SW-1:0] st;
    int nr, ed;
    for (int it = 0; it < 6; it++) begin
      nr = $urandom_range(1, 12);
      st = rand_state();
      fill_valid(55);
      ed = exp_done(nr);
      run_perm(4'(nr), st, -1, -1, -1);
      n_checks++;
      if (r_done !== ed || unshare(r_res) !== ref_perm(unshare(st), nr)) begin
        n_fail++; $display("FAIL rand_run%0d: R=%0d done at %0d required %0d, result ok=%b",
                           it, nr, r_done, ed, unshare(r_res) === ref_perm(unshare(st), nr));
      end
      n_checks++;
      if (r_hs !== nr || r_rdi_err !== 0) begin
        n_fail++; $display("FAIL rand_rnd%0d: handshakes %0d rdi errors %0d, required %0d and 0",
                           it, r_hs, r_rdi_err, nr);
      end
      check_cnt_seq("rand_cnt", nr);
    end
  endtask

  task automatic test_abort();
    logic [SW-1:0] st = rand_state();
    fill_valid(100);
    run_perm(4'd12, st, -1, -1, 14);
    n_checks++;
    if (r_abort_zero !== 1'b1) begin
      n_fail++; $display("FAIL abort_zero: outputs zero=%b during reset, required 1", r_abort_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    st = rand_state();
    run_perm(4'd12, st, -1, -1, -1);
    n_checks++;
    if (r_done !== 26 || unshare(r_res) !== ref_perm(unshare(st), 12)) begin
      n_fail++; $display("FAIL abort_restart: done at %0d result ok=%b, required 26 and p12",
                         r_done, unshare(r_res) === ref_perm(unshare(st), 12));
    end
  endtask

  initial begin
    test_reset();
    test_p12_zero();
    test_p6_masked();
    test_stall();
    test_clamp_and_ignore();
    test_random_valid();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
